// File: rtl/sine_tone_pwm.sv
// rtl/sine_tone_pwm.sv - semitone-coded sine tone generator with volume-scaled 8-bit PWM output
module sine_tone_pwm (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] TONE,
    input  logic [3:0] VOL,
    output logic       P
);

    localparam logic [13:0] PERIOD_MAX = 14'd11945;

    logic [13:0] cnt;
    logic [5:0]  ph;
    logic [7:0]  pc;
    logic [13:0] period;
    logic [7:0]  duty;
    logic [11:0] prod;
    logic [7:0]  scaled;
    logic        active;

    // Clocks per phase step minus one: round(1562500 / f_note) - 1
    always_comb begin
        period = 14'd0;
        case (TONE)
            6'd1:  period = 14'd11944;
            6'd2:  period = 14'd11273;
            6'd3:  period = 14'd10640;
            6'd4:  period = 14'd10043;
            6'd5:  period = 14'd9479;
            6'd6:  period = 14'd8947;
            6'd7:  period = 14'd8445;
            6'd8:  period = 14'd7971;
            6'd9:  period = 14'd7524;
            6'd10: period = 14'd7101;
            6'd11: period = 14'd6703;
            6'd12: period = 14'd6326;
            6'd13: period = 14'd5971;
            6'd14: period = 14'd5636;
            6'd15: period = 14'd5320;
            6'd16: period = 14'd5021;
            6'd17: period = 14'd4739;
            6'd18: period = 14'd4473;
            6'd19: period = 14'd4222;
            6'd20: period = 14'd3985;
            6'd21: period = 14'd3761;
            6'd22: period = 14'd3550;
            6'd23: period = 14'd3351;
            6'd24: period = 14'd3163;
            6'd25: period = 14'd2985;
            6'd26: period = 14'd2818;
            6'd27: period = 14'd2659;
            6'd28: period = 14'd2510;
            6'd29: period = 14'd2369;
            6'd30: period = 14'd2236;
            6'd31: period = 14'd2111;
            6'd32: period = 14'd1992;
            6'd33: period = 14'd1880;
            6'd34: period = 14'd1775;
            6'd35: period = 14'd1675;
            6'd36: period = 14'd1581;
            6'd37: period = 14'd1492;
            6'd38: period = 14'd1408;
            6'd39: period = 14'd1329;
            6'd40: period = 14'd1255;
            6'd41: period = 14'd1184;
            6'd42: period = 14'd1118;
            6'd43: period = 14'd1055;
            6'd44: period = 14'd996;
            6'd45: period = 14'd940;
            6'd46: period = 14'd887;
            6'd47: period = 14'd837;
            6'd48: period = 14'd790;
            6'd49: period = 14'd746;
            6'd50: period = 14'd704;
            6'd51: period = 14'd664;
            6'd52: period = 14'd627;
            6'd53: period = 14'd592;
            6'd54: period = 14'd558;
            6'd55: period = 14'd527;
            6'd56: period = 14'd497;
            6'd57: period = 14'd469;
            6'd58: period = 14'd443;
            6'd59: period = 14'd418;
            6'd60: period = 14'd394;
            6'd61: period = 14'd372;
            6'd62: period = 14'd351;
            6'd63: period = 14'd332;
            default: period = 14'd0;
        endcase
    end

    // duty(k) = round(128 + 127*sin(2*pi*k/64))
    always_comb begin
        duty = 8'd128;
        case (ph)
            6'd0:  duty = 8'd128;  6'd1:  duty = 8'd140;  6'd2:  duty = 8'd153;  6'd3:  duty = 8'd165;
            6'd4:  duty = 8'd177;  6'd5:  duty = 8'd188;  6'd6:  duty = 8'd199;  6'd7:  duty = 8'd209;
            6'd8:  duty = 8'd218;  6'd9:  duty = 8'd226;  6'd10: duty = 8'd234;  6'd11: duty = 8'd240;
            6'd12: duty = 8'd245;  6'd13: duty = 8'd250;  6'd14: duty = 8'd253;  6'd15: duty = 8'd254;
            6'd16: duty = 8'd255;  6'd17: duty = 8'd254;  6'd18: duty = 8'd253;  6'd19: duty = 8'd250;
            6'd20: duty = 8'd245;  6'd21: duty = 8'd240;  6'd22: duty = 8'd234;  6'd23: duty = 8'd226;
            6'd24: duty = 8'd218;  6'd25: duty = 8'd209;  6'd26: duty = 8'd199;  6'd27: duty = 8'd188;
            6'd28: duty = 8'd177;  6'd29: duty = 8'd165;  6'd30: duty = 8'd153;  6'd31: duty = 8'd140;
            6'd32: duty = 8'd128;  6'd33: duty = 8'd116;  6'd34: duty = 8'd103;  6'd35: duty = 8'd91;
            6'd36: duty = 8'd79;   6'd37: duty = 8'd68;   6'd38: duty = 8'd57;   6'd39: duty = 8'd47;
            6'd40: duty = 8'd38;   6'd41: duty = 8'd30;   6'd42: duty = 8'd22;   6'd43: duty = 8'd16;
            6'd44: duty = 8'd11;   6'd45: duty = 8'd6;    6'd46: duty = 8'd3;    6'd47: duty = 8'd2;
            6'd48: duty = 8'd1;    6'd49: duty = 8'd2;    6'd50: duty = 8'd3;    6'd51: duty = 8'd6;
            6'd52: duty = 8'd11;   6'd53: duty = 8'd16;   6'd54: duty = 8'd22;   6'd55: duty = 8'd30;
            6'd56: duty = 8'd38;   6'd57: duty = 8'd47;   6'd58: duty = 8'd57;   6'd59: duty = 8'd68;
            6'd60: duty = 8'd79;   6'd61: duty = 8'd91;   6'd62: duty = 8'd103;  6'd63: duty = 8'd116;
            default: duty = 8'd128;
        endcase
    end

    assign prod   = {4'b0000, duty} * {8'b0000_0000, VOL};
    assign scaled = prod[11:4];
    assign active = (TONE != 6'd0) && (VOL != 4'd0);

    // The cnt > PERIOD_MAX guard recovers from any out-of-range count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= 14'd0;
            ph  <= 6'd0;
            pc  <= 8'd0;
            P   <= 1'b0;
        end else begin
            pc <= pc + 8'd1;
            P  <= active && (pc < scaled);
            if (active) begin
                if ((cnt >= period) || (cnt > PERIOD_MAX)) begin
                    cnt <= 14'd0;
                    ph  <= ph + 6'd1;
                end else begin
                    cnt <= cnt + 14'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_tone_pwm.sv
// tb/tb_sine_tone_pwm.sv - self-checking bench for sine_tone_pwm
module tb_sine_tone_pwm;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] TONE;
    logic [3:0] VOL;
    logic       P;

    int tests = 0;
    int fails = 0;

    sine_tone_pwm dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .TONE  (TONE),
        .VOL   (VOL),
        .P     (P)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ph;
        int vol;
        int exp_hi;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ph(input int target, input int bound);
        int n;
        n = 0;
        while (int'(dut.ph) != target && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic count_high(input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            tick();
            if (P) hi++;
        end
    endtask

    task automatic steps_until_ph_change(input int bound, output int n);
        int ph0;
        ph0 = int'(dut.ph);
        n = 0;
        while (int'(dut.ph) == ph0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, hi, ph_h, cnt_h, pc0;

        vecs[0]  = '{ph: 0,  vol: 15, exp_hi: 120};
        vecs[1]  = '{ph: 4,  vol: 7,  exp_hi: 77};
        vecs[2]  = '{ph: 8,  vol: 15, exp_hi: 204};
        vecs[3]  = '{ph: 16, vol: 15, exp_hi: 239};
        vecs[4]  = '{ph: 20, vol: 4,  exp_hi: 61};
        vecs[5]  = '{ph: 24, vol: 1,  exp_hi: 13};
        vecs[6]  = '{ph: 32, vol: 15, exp_hi: 120};
        vecs[7]  = '{ph: 40, vol: 15, exp_hi: 35};
        vecs[8]  = '{ph: 44, vol: 0,  exp_hi: 0};
        vecs[9]  = '{ph: 48, vol: 15, exp_hi: 0};
        vecs[10] = '{ph: 63, vol: 15, exp_hi: 108};

        // Reset state and first step latency at A4
        RST_N = 1'b0;
        TONE  = 6'd22;
        VOL   = 4'd15;
        repeat (3) tick();
        check("rst_P", int'(P), 0);
        check("rst_ph", int'(dut.ph), 0);
        check("rst_cnt", int'(dut.cnt), 0);
        RST_N = 1'b1;
        steps_until_ph_change(4000, n);
        check("a4_first_step", n, 3551);
        check("a4_cnt_after_step", int'(dut.cnt), 0);
        check("a4_ph_after_step", int'(dut.ph), 1);

        // Table-driven duty/volume vectors at the highest note
        RST_N = 1'b0;
        tick();
        TONE  = 6'd63;
        VOL   = 4'd15;
        RST_N = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wait_ph(vecs[i].ph, 64 * 340);
            check($sformatf("reach_ph%0d", vecs[i].ph), int'(dut.ph), vecs[i].ph);
            VOL = 4'(vecs[i].vol);
            cnt_h = int'(dut.cnt);
            count_high(256, hi);
            check($sformatf("duty_ph%0d_vol%0d", vecs[i].ph, vecs[i].vol), hi, vecs[i].exp_hi);
            if (vecs[i].vol == 0) begin
                check("vol0_ph_frozen", int'(dut.ph), vecs[i].ph);
                check("vol0_cnt_frozen", int'(dut.cnt), cnt_h);
            end
            VOL = 4'd15;
        end

        // Step spacing at TONE=63 and mid-step tone change
        steps_until_ph_change(400, n);
        steps_until_ph_change(400, n);
        check("t63_step", n, 333);

        RST_N = 1'b0;
        tick();
        TONE  = 6'd1;
        VOL   = 4'd15;
        RST_N = 1'b1;
        n = 0;
        while (int'(dut.cnt) != 5000 && n < 6000) begin
            tick();
            n++;
        end
        check("t1_cnt5000", int'(dut.cnt), 5000);
        ph_h = int'(dut.ph);
        TONE = 6'd63;
        tick();
        check("switch_cnt", int'(dut.cnt), 0);
        check("switch_ph", int'(dut.ph), (ph_h + 1) % 64);
        steps_until_ph_change(400, n);
        check("switch_next_step", n, 333);

        // Rest: output silent, phase and count held, carrier keeps running
        repeat (17) tick();
        TONE  = 6'd0;
        ph_h  = int'(dut.ph);
        cnt_h = int'(dut.cnt);
        pc0   = int'(dut.pc);
        count_high(300, hi);
        check("rest_P_low", hi, 0);
        check("rest_ph_held", int'(dut.ph), ph_h);
        check("rest_cnt_held", int'(dut.cnt), cnt_h);
        check("rest_pc_runs", (int'(dut.pc) - pc0) & 255, 300 % 256);
        TONE = 6'd22;
        tick();
        check("resume_ph", int'(dut.ph), ph_h);
        check("resume_cnt", int'(dut.cnt), cnt_h + 1);

        // Asynchronous reset asserted between clock edges
        repeat (5) tick();
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_ph", int'(dut.ph), 0);
        check("async_rst_cnt", int'(dut.cnt), 0);
        check("async_rst_pc", int'(dut.pc), 0);
        check("async_rst_P", int'(P), 0);
        repeat (2) tick();
        check("held_rst_ph", int'(dut.ph), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
